// File: rtl/action_queue_if.sv
// action_queue_if: parser-to-exec action handshake carried through the action queue.
interface action_queue_if;
    logic        I_VALID;
    logic [15:0] I_SHIFT;
    logic [15:0] I_REDUCE;
    logic        O_READY;
    logic        O_VALID;
    logic [15:0] O_SHIFT;
    logic [15:0] O_REDUCE;
    logic        I_RECEIVE;
    modport master (
        output I_VALID, I_SHIFT, I_REDUCE, I_RECEIVE,
        input  O_READY, O_VALID, O_SHIFT, O_REDUCE
    );
    modport slave (
        input  I_VALID, I_SHIFT, I_REDUCE, I_RECEIVE,
        output O_READY, O_VALID, O_SHIFT, O_REDUCE
    );
endinterface

// File: rtl/action_queue.sv
// action_queue: 8-entry shift/reduce action FIFO with a value-stack depth model and sticky error.
module action_queue (
    input  logic          CLK,
    input  logic          RST,
    action_queue_if.slave aq,
    output logic          O_ERROR,
    output logic [10:0]   O_DEPTH,
    output logic [3:0]    O_COUNT
);
    logic [16:0] mem_q [8];
    logic [2:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [3:0]  count_q, count_d;
    logic [10:0] depth_q, depth_d;
    logic        error_q, error_d;
    logic [16:0] entry_d, head;
    logic [3:0]  rule;
    logic [1:0]  pop;
    logic        push, is_shift, is_value, filtered, bad_rule, underflow, overflow;
    logic        accept, enq, deq;
    logic        unused_reduce_hi;
    assign unused_reduce_hi = ^aq.I_REDUCE[15:4];
    assign head        = mem_q[rd_ptr_q];
    assign aq.O_VALID  = count_q != 4'd0;
    assign aq.O_READY  = (count_q < 4'd8) && !error_q;
    assign aq.O_SHIFT  = (aq.O_VALID && !head[16]) ? head[15:0] : 16'h0;
    assign aq.O_REDUCE = (aq.O_VALID && head[16]) ? head[15:0] : 16'h0;
    assign O_ERROR     = error_q;
    assign O_DEPTH     = depth_q;
    assign O_COUNT     = count_q;
    always_comb begin
        rule      = aq.I_REDUCE[3:0];
        is_shift  = aq.I_SHIFT != 16'h0;
        is_value  = is_shift && aq.I_SHIFT[15:8] == 8'h00;
        pop       = (rule == 4'd8 || rule == 4'd9) ? 2'd2 : 2'd1;
        push      = rule >= 4'd8;
        filtered  = !is_shift && rule <= 4'd1;
        bad_rule  = !is_shift && rule >= 4'd13;
        underflow = !is_shift && !filtered && !bad_rule && depth_q < {9'd0, pop};
        overflow  = is_value && depth_q == 11'd1024;
        accept    = aq.I_VALID && aq.O_READY;
        enq       = accept && !filtered && !bad_rule && !underflow && !overflow;
        deq       = aq.O_VALID && aq.I_RECEIVE;
        wr_ptr_d  = wr_ptr_q + {2'b0, enq};
        rd_ptr_d  = rd_ptr_q + {2'b0, deq};
        count_d   = count_q + {3'b0, enq} - {3'b0, deq};
        error_d   = error_q || (accept && (bad_rule || underflow || overflow));
        // depth follows accepted actions only; rejected and filtered ones leave it alone
        depth_d   = !enq ? depth_q :
                    is_shift ? depth_q + {10'd0, is_value} :
                    depth_q - {9'd0, pop} + {10'd0, push};
        entry_d   = is_shift ? {1'b0, aq.I_SHIFT} : {1'b1, 12'h0, rule};
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= 3'd0;
            rd_ptr_q <= 3'd0;
            count_q  <= 4'd0;
            depth_q  <= 11'd0;
            error_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            depth_q  <= depth_d;
            error_q  <= error_d;
        end
    end
    always_ff @(posedge CLK) begin
        if (!RST && enq) mem_q[wr_ptr_q] <= entry_d;
    end
endmodule

// File: tb/tb_action_queue.sv
// tb_action_queue: directed vectors with hand-computed expectations for action_queue.
module tb_action_queue;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        O_ERROR;
    logic [10:0] O_DEPTH;
    logic [3:0]  O_COUNT;
    int          checks = 0;
    int          errors = 0;
    int          q [$];
    action_queue_if aq();
    action_queue u_dut (
        .CLK     (CLK),
        .RST     (RST),
        .aq      (aq.slave),
        .O_ERROR (O_ERROR),
        .O_DEPTH (O_DEPTH),
        .O_COUNT (O_COUNT)
    );
    always #5 CLK = ~CLK;
    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic set(input logic v, input logic [15:0] s, input logic [15:0] r, input logic rx);
        aq.I_VALID   = v;
        aq.I_SHIFT   = s;
        aq.I_REDUCE  = r;
        aq.I_RECEIVE = rx;
    endtask
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask
    task automatic cyc(input logic v, input logic [15:0] s, input logic [15:0] r, input logic rx);
        set(v, s, r, rx);
        tick();
    endtask
    task automatic do_reset();
        RST = 1'b1;
        cyc(0, 16'h0, 16'h0, 0);
        RST = 1'b0;
    endtask
    initial begin
        do_reset();
        chk("rst_valid", aq.O_VALID, 0);
        chk("rst_shift", aq.O_SHIFT, 0);
        chk("rst_reduce", aq.O_REDUCE, 0);
        chk("rst_error", O_ERROR, 0);
        chk("rst_depth", O_DEPTH, 0);
        chk("rst_count", O_COUNT, 0);
        chk("rst_ready", aq.O_READY, 1);
        // basic flow with the exec stage always receiving
        cyc(1, 16'h0003, 16'h0, 1);
        chk("bf1_valid", aq.O_VALID, 1);
        chk("bf1_shift", aq.O_SHIFT, 16'h0003);
        chk("bf1_depth", O_DEPTH, 1);
        cyc(1, 16'h0004, 16'h0, 1);
        chk("bf2_shift", aq.O_SHIFT, 16'h0004);
        chk("bf2_count", O_COUNT, 1);
        chk("bf2_depth", O_DEPTH, 2);
        cyc(1, 16'h0000, 16'h0008, 1);
        chk("bf3_reduce", aq.O_REDUCE, 8);
        chk("bf3_shift", aq.O_SHIFT, 0);
        chk("bf3_depth", O_DEPTH, 1);
        cyc(0, 16'h0, 16'h0, 1);
        chk("bf4_valid", aq.O_VALID, 0);
        chk("bf4_reduce", aq.O_REDUCE, 0);
        // backpressure: nine value shifts, no receive
        do_reset();
        for (int i = 0; i < 9; i++) begin
            set(1, 16'h0010 + 16'(i), 16'h0, 0);
            chk($sformatf("bp_ready%0d", i), aq.O_READY, (i < 8) ? 1 : 0);
            tick();
        end
        chk("bp_count", O_COUNT, 8);
        chk("bp_depth", O_DEPTH, 8);
        chk("bp_head", aq.O_SHIFT, 16'h0010);
        cyc(0, 16'h0, 16'h0, 0);
        chk("bp_hold", aq.O_SHIFT, 16'h0010);
        // drain while nearly full with simultaneous accept; pointers wrap
        cyc(0, 16'h0, 16'h0, 1);
        chk("dr_count7", O_COUNT, 7);
        for (int i = 0; i < 7; i++) q.push_back(16'h0011 + i);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("dr_head%0d", k), aq.O_SHIFT, q[0]);
            set(1, 16'h0020 + 16'(k), 16'h0, 1);
            chk($sformatf("dr_ready%0d", k), aq.O_READY, 1);
            tick();
            void'(q.pop_front());
            q.push_back(16'h0020 + k);
            chk($sformatf("dr_count%0d", k), O_COUNT, 7);
        end
        chk("dr_depth", O_DEPTH, 18);
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("dr_tail%0d", k), aq.O_SHIFT, q[0]);
            cyc(0, 16'h0, 16'h0, 1);
            void'(q.pop_front());
        end
        chk("dr_empty", O_COUNT, 0);
        chk("dr_valid", aq.O_VALID, 0);
        // underflow: reduce 9 at depth 1
        do_reset();
        cyc(1, 16'h0005, 16'h0, 0);
        cyc(1, 16'h0000, 16'h0009, 0);
        chk("uf_error", O_ERROR, 1);
        chk("uf_depth", O_DEPTH, 1);
        chk("uf_ready", aq.O_READY, 0);
        chk("uf_count", O_COUNT, 1);
        cyc(1, 16'h0006, 16'h0, 0);
        chk("uf_noacc", O_COUNT, 1);
        chk("uf_head", aq.O_SHIFT, 16'h0005);
        cyc(0, 16'h0, 16'h0, 1);
        chk("uf_drain", O_COUNT, 0);
        // filter, non-value shift, rule 3 with junk upper bits, invalid rule
        do_reset();
        cyc(1, 16'h0007, 16'h0, 0);
        cyc(1, 16'h0100, 16'h0, 0);
        chk("nv_depth", O_DEPTH, 1);
        cyc(1, 16'h0000, 16'hABC3, 0);
        chk("r3_depth", O_DEPTH, 0);
        chk("r3_count", O_COUNT, 3);
        cyc(1, 16'h0000, 16'hFFF0, 0);
        chk("r0_count", O_COUNT, 3);
        cyc(1, 16'h0000, 16'h0001, 0);
        chk("r1_count", O_COUNT, 3);
        chk("r1_error", O_ERROR, 0);
        cyc(1, 16'h0000, 16'h000E, 0);
        chk("r14_count", O_COUNT, 3);
        chk("r14_error", O_ERROR, 1);
        chk("r14_depth", O_DEPTH, 0);
        chk("fo_h0", aq.O_SHIFT, 16'h0007);
        cyc(0, 16'h0, 16'h0, 1);
        chk("fo_h1", aq.O_SHIFT, 16'h0100);
        cyc(0, 16'h0, 16'h0, 1);
        chk("fo_h2r", aq.O_REDUCE, 3);
        chk("fo_h2s", aq.O_SHIFT, 0);
        // reset mid-stream with error set; accept and receive during reset ignored
        do_reset();
        cyc(1, 16'h0001, 16'h0, 0);
        cyc(1, 16'h0002, 16'h0, 0);
        cyc(1, 16'h0003, 16'h0, 0);
        cyc(1, 16'h0000, 16'h000F, 0);
        chk("rm_error", O_ERROR, 1);
        chk("rm_count", O_COUNT, 3);
        RST = 1'b1;
        cyc(1, 16'h0009, 16'h0, 1);
        RST = 1'b0;
        set(0, 16'h0, 16'h0, 0);
        chk("rm_valid", aq.O_VALID, 0);
        chk("rm_shift", aq.O_SHIFT, 0);
        chk("rm_err0", O_ERROR, 0);
        chk("rm_depth", O_DEPTH, 0);
        chk("rm_cnt0", O_COUNT, 0);
        chk("rm_ready", aq.O_READY, 1);
        cyc(1, 16'h0005, 16'h0, 0);
        chk("rm_fresh_v", aq.O_VALID, 1);
        chk("rm_fresh_s", aq.O_SHIFT, 16'h0005);
        // overflow at depth 1024
        do_reset();
        for (int i = 0; i < 1024; i++) cyc(1, 16'h0001, 16'h0, 1);
        chk("of_depth", O_DEPTH, 1024);
        chk("of_count", O_COUNT, 1);
        chk("of_err0", O_ERROR, 0);
        cyc(1, 16'h0002, 16'h0, 0);
        chk("of_error", O_ERROR, 1);
        chk("of_depth2", O_DEPTH, 1024);
        chk("of_count2", O_COUNT, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
